// File: rtl/cache_mem_arbiter.sv
// Shares one 128-bit memory port between Icache refills and Dcache refills/writebacks.
// Define CACHE_ARB_DPRIO_EN for fixed Dcache priority; otherwise ties are round-robin.
module cache_mem_arbiter (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [31:0]  icache_addr_i,
    input  logic         icache_valid_req_i,
    output logic         icache_ready_o,
    output logic [127:0] icache_data_o,
    input  logic [31:0]  dcache_addr_i,
    input  logic         dcache_valid_req_i,
    input  logic         dcache_we_i,
    input  logic [127:0] dcache_wdata_i,
    output logic         dcache_ready_o,
    output logic [127:0] dcache_rdata_o,
    output logic [31:0]  mem_addr_o,
    output logic         mem_valid_req_o,
    output logic         mem_we_o,
    output logic [127:0] mem_wdata_o,
    input  logic         mem_ready_i,
    input  logic [127:0] mem_rdata_i
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] I_BUSY = 2'd1;
    localparam logic [1:0] D_BUSY = 2'd2;

    logic [1:0]   state;
    logic [31:0]  i_addr;
    logic         i_pend;
    logic [31:0]  d_addr;
    logic         d_we;
    logic [127:0] d_wdata;
    logic         d_pend;
    logic         stale;
    logic         last_grant_d;

    logic         i_vis;
    logic         d_vis;
    logic         d_accept;
    logic         grant_i;
    logic         grant_d;
    logic [31:0]  i_req_addr;
    logic [31:0]  d_req_addr;
    logic         d_req_we;
    logic [127:0] d_req_wdata;

    // A Dcache pulse while its own transaction is open is dropped, unless that
    // transaction completes in the same cycle.
    assign d_accept = dcache_valid_req_i && ((state != D_BUSY) || mem_ready_i);

    // The current-cycle pulse bypasses the slot so an idle arbiter issues immediately.
    assign i_vis       = i_pend || icache_valid_req_i;
    assign d_vis       = d_pend || dcache_valid_req_i;
    assign i_req_addr  = icache_valid_req_i ? icache_addr_i  : i_addr;
    assign d_req_addr  = dcache_valid_req_i ? dcache_addr_i  : d_addr;
    assign d_req_we    = dcache_valid_req_i ? dcache_we_i    : d_we;
    assign d_req_wdata = dcache_valid_req_i ? dcache_wdata_i : d_wdata;

    always_comb begin
        // NOTE: give every always_comb output a default first so no path infers a latch.
        grant_i = 1'b0;
        grant_d = 1'b0;
        if (state == IDLE) begin
            if (i_vis && d_vis) begin
`ifdef CACHE_ARB_DPRIO_EN
                grant_d = 1'b1;
`else
                grant_i = last_grant_d;
                grant_d = !last_grant_d;
`endif
            end else begin
                grant_i = i_vis;
                grant_d = d_vis;
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state updates use non-blocking assignments so every register sees pre-edge values.
        if (!rst_n) begin
            state           <= IDLE;
            i_addr          <= '0;
            i_pend          <= 1'b0;
            d_addr          <= '0;
            d_we            <= 1'b0;
            d_wdata         <= '0;
            d_pend          <= 1'b0;
            stale           <= 1'b0;
            last_grant_d    <= 1'b1;
            icache_ready_o  <= 1'b0;
            icache_data_o   <= '0;
            dcache_ready_o  <= 1'b0;
            dcache_rdata_o  <= '0;
            mem_addr_o      <= '0;
            mem_valid_req_o <= 1'b0;
            mem_we_o        <= 1'b0;
            mem_wdata_o     <= '0;
        end else begin
            mem_valid_req_o <= 1'b0;
            icache_ready_o  <= 1'b0;
            dcache_ready_o  <= 1'b0;

            if (icache_valid_req_i) begin
                i_addr <= icache_addr_i;
                i_pend <= 1'b1;
            end
            if (d_accept) begin
                d_addr  <= dcache_addr_i;
                d_we    <= dcache_we_i;
                d_wdata <= dcache_wdata_i;
                d_pend  <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (grant_i) begin
                        i_pend          <= 1'b0;
                        state           <= I_BUSY;
                        mem_valid_req_o <= 1'b1;
                        mem_addr_o      <= i_req_addr;
                        mem_we_o        <= 1'b0;
                        last_grant_d    <= 1'b0;
                    end else if (grant_d) begin
                        d_pend          <= 1'b0;
                        state           <= D_BUSY;
                        mem_valid_req_o <= 1'b1;
                        mem_addr_o      <= d_req_addr;
                        mem_we_o        <= d_req_we;
                        mem_wdata_o     <= d_req_wdata;
                        last_grant_d    <= 1'b1;
                    end
                end
                I_BUSY: begin
                    if (mem_ready_i) begin
                        state    <= IDLE;
                        mem_we_o <= 1'b0;
                        stale    <= 1'b0;
                        // A superseded refill is swallowed; the re-request is already in the slot.
                        if (!stale) begin
                            icache_ready_o <= 1'b1;
                            icache_data_o  <= mem_rdata_i;
                        end
                    end else if (icache_valid_req_i) begin
                        stale <= 1'b1;
                    end
                end
                D_BUSY: begin
                    if (mem_ready_i) begin
                        state          <= IDLE;
                        mem_we_o       <= 1'b0;
                        dcache_ready_o <= 1'b1;
                        if (!mem_we_o) dcache_rdata_o <= mem_rdata_i;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
